// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the ALU execute/writeback stage:
//     - datapath width
//     - ALU control codes (OP_ADD .. OP_CMP, OP_LAST_LEGAL)
//     - bit positions inside the 5-bit flag vector {zero, eq, lt, ovf, carry}
//     - FSM state encodings of alu_exec_unit
//     - small opcode classification helpers
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int XLEN   = 32;
    localparam int FLAG_W = 5;

    // ALU control codes
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_MUL = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_LSL = 4'd3;
    localparam logic [3:0] OP_LSR = 4'd4;
    localparam logic [3:0] OP_ASR = 4'd5;
    localparam logic [3:0] OP_AND = 4'd6;
    localparam logic [3:0] OP_OR  = 4'd7;
    localparam logic [3:0] OP_NOT = 4'd8;
    localparam logic [3:0] OP_XOR = 4'd9;
    localparam logic [3:0] OP_CMP = 4'd10;
    localparam logic [3:0] OP_LAST_LEGAL = OP_CMP;

    // Flag bit indices (rsp_flags / flags_q)
    localparam int FLG_CARRY    = 0;
    localparam int FLG_OVERFLOW = 1;
    localparam int FLG_LESSTHAN = 2;
    localparam int FLG_EQUALTO  = 3;
    localparam int FLG_ZERO     = 4;

    // FSM states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    function automatic logic op_is_legal(input logic [3:0] op);
        return op <= OP_LAST_LEGAL;
    endfunction

    // cmp only produces flags; everything else legal writes its result back.
    function automatic logic op_writes_rd(input logic [3:0] op);
        return op_is_legal(op) && (op != OP_CMP);
    endfunction

endpackage : alu_pkg

// File: rtl/alu_regfile.sv
// ---------------------------------------------------------------------------
// alu_regfile
//   NREGS x XLEN register file with one combinational read pair and one
//   synchronous write port. r0 always reads as zero and writes to it are
//   dropped. All entries clear on asynchronous reset.
//
//   Optional macro ALU_EXEC_DBG_EN adds a third combinational read port
//   (dbg_addr/dbg_data) used for debug observation.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   ra_addr / ra_data   read port A
//   rb_addr / rb_data   read port B
//   we, wa, wd          write enable, address, data
//   dbg_addr/dbg_data   (ALU_EXEC_DBG_EN only) debug read port
// ---------------------------------------------------------------------------
module alu_regfile
    import alu_pkg::*;
#(
    parameter int NREGS = 8,
    parameter int RW    = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [RW-1:0]   ra_addr,
    output logic [XLEN-1:0] ra_data,
    input  logic [RW-1:0]   rb_addr,
    output logic [XLEN-1:0] rb_data,
    input  logic            we,
    input  logic [RW-1:0]   wa,
    input  logic [XLEN-1:0] wd
`ifdef ALU_EXEC_DBG_EN
    ,
    input  logic [RW-1:0]   dbg_addr,
    output logic [XLEN-1:0] dbg_data
`endif
);

    logic [XLEN-1:0] mem_q [NREGS];
    logic [XLEN-1:0] mem_d [NREGS];

    assign ra_data = (ra_addr == '0) ? '0 : mem_q[ra_addr];
    assign rb_data = (rb_addr == '0) ? '0 : mem_q[rb_addr];
`ifdef ALU_EXEC_DBG_EN
    assign dbg_data = (dbg_addr == '0) ? '0 : mem_q[dbg_addr];
`endif

    always_comb begin
        mem_d = mem_q;
        if (we && (wa != '0)) begin
            mem_d[wa] = wd;
        end
    end

    // NOTE: the array is cleared on reset because an aborted or fresh run must
    //       read zeros from every register; this forces flops rather than RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

endmodule : alu_regfile

// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit
//   Single-issue issue/writeback stage wrapped around an external
//   combinational 32-bit ALU. A command is accepted in IDLE, its operands
//   are read from the local register file and registered onto the ALU
//   ports, held through EXEC, then the ALU result and flags are captured,
//   written back, and presented as a response until it is taken.
//
//   Optional macro ALU_EXEC_DBG_EN adds dbg_addr/dbg_data (register peek)
//   and dbg_op_cnt (saturating count of completed legal operations).
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   cmd_valid/cmd_ready              command handshake
//   cmd_op, cmd_rd, cmd_ra, cmd_rb   ALU code and register addresses
//   cmd_imm_sel, cmd_imm             immediate replaces reg[rb] when set
//   alu_a, alu_b, alu_control        registered drive to the ALU
//   alu_s, alu_carry .. alu_zero     ALU result and flags
//   rsp_valid/rsp_ready              response handshake
//   rsp_data, rsp_flags, rsp_err     captured result, flags, illegal-op flag
//   flags_q                          architectural flags {z, eq, lt, v, c}
// ---------------------------------------------------------------------------
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int NREGS       = 8,
    parameter int RW          = 3,
    parameter int EXEC_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_op,
    input  logic [RW-1:0]     cmd_rd,
    input  logic [RW-1:0]     cmd_ra,
    input  logic [RW-1:0]     cmd_rb,
    input  logic              cmd_imm_sel,
    input  logic [31:0]       cmd_imm,
    output logic [31:0]       alu_a,
    output logic [31:0]       alu_b,
    output logic [3:0]        alu_control,
    input  logic [31:0]       alu_s,
    input  logic              alu_carry,
    input  logic              alu_overflow,
    input  logic              alu_lessthan,
    input  logic              alu_equalto,
    input  logic              alu_zero,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_data,
    output logic [4:0]        rsp_flags,
    output logic              rsp_err,
    output logic [4:0]        flags_q
`ifdef ALU_EXEC_DBG_EN
    ,
    input  logic [RW-1:0]     dbg_addr,
    output logic [31:0]       dbg_data,
    output logic [15:0]       dbg_op_cnt
`endif
);

    // The counter also spans the cycle in which freshly registered operands
    // propagate through the ALU, so it is loaded with EXEC_CYCLES and the
    // capture lands EXEC_CYCLES+1 edges after accept.
    localparam int CNT_W = $clog2(EXEC_CYCLES + 1);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [RW-1:0]     rd_q, rd_d;
    logic [XLEN-1:0]   alu_a_q, alu_a_d;
    logic [XLEN-1:0]   alu_b_q, alu_b_d;
    logic [3:0]        alu_ctrl_q, alu_ctrl_d;
    logic [XLEN-1:0]   rsp_data_q, rsp_data_d;
    logic [FLAG_W-1:0] rsp_flags_q, rsp_flags_d;
    logic              rsp_err_q, rsp_err_d;
    logic [FLAG_W-1:0] flags_d;
    logic [FLAG_W-1:0] alu_flags;

    logic [XLEN-1:0]   rf_ra_data, rf_rb_data;
    logic              rf_we;

`ifdef ALU_EXEC_DBG_EN
    logic [15:0]       op_cnt_q, op_cnt_d;
`endif

    alu_regfile #(
        .NREGS (NREGS),
        .RW    (RW)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .ra_addr  (cmd_ra),
        .ra_data  (rf_ra_data),
        .rb_addr  (cmd_rb),
        .rb_data  (rf_rb_data),
        .we       (rf_we),
        .wa       (rd_q),
        .wd       (alu_s)
`ifdef ALU_EXEC_DBG_EN
        ,
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
`endif
    );

    // NOTE: every signal written below gets a default first, so no path
    //       through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        alu_flags               = '0;
        alu_flags[FLG_CARRY]    = alu_carry;
        alu_flags[FLG_OVERFLOW] = alu_overflow;
        alu_flags[FLG_LESSTHAN] = alu_lessthan;
        alu_flags[FLG_EQUALTO]  = alu_equalto;
        alu_flags[FLG_ZERO]     = alu_zero;

        state_d     = state_q;
        cnt_d       = cnt_q;
        rd_d        = rd_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_ctrl_d  = alu_ctrl_q;
        rsp_data_d  = rsp_data_q;
        rsp_flags_d = rsp_flags_q;
        rsp_err_d   = rsp_err_q;
        flags_d     = flags_q;
        rf_we       = 1'b0;
`ifdef ALU_EXEC_DBG_EN
        op_cnt_d    = op_cnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    alu_a_d    = rf_ra_data;
                    alu_b_d    = cmd_imm_sel ? cmd_imm : rf_rb_data;
                    alu_ctrl_d = cmd_op;
                    rd_d       = cmd_rd;
                    cnt_d      = CNT_W'(EXEC_CYCLES);
                    state_d    = ST_EXEC;
                end
            end

            ST_EXEC: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    if (op_is_legal(alu_ctrl_q)) begin
                        rsp_data_d  = alu_s;
                        rsp_flags_d = alu_flags;
                        rsp_err_d   = 1'b0;
                        flags_d     = alu_flags;
                        rf_we       = op_writes_rd(alu_ctrl_q);
`ifdef ALU_EXEC_DBG_EN
                        if (op_cnt_q != 16'hFFFF) begin
                            op_cnt_d = op_cnt_q + 16'd1;
                        end
`endif
                    end else begin
                        // Illegal codes report an error and leave all
                        // architectural state untouched.
                        rsp_data_d  = '0;
                        rsp_flags_d = '0;
                        rsp_err_d   = 1'b1;
                    end
                    state_d = ST_RESP;
                end
            end

            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    //       samples its pre-edge _d value regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rd_q        <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_ctrl_q  <= '0;
            rsp_data_q  <= '0;
            rsp_flags_q <= '0;
            rsp_err_q   <= 1'b0;
            flags_q     <= '0;
`ifdef ALU_EXEC_DBG_EN
            op_cnt_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rd_q        <= rd_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_ctrl_q  <= alu_ctrl_d;
            rsp_data_q  <= rsp_data_d;
            rsp_flags_q <= rsp_flags_d;
            rsp_err_q   <= rsp_err_d;
            flags_q     <= flags_d;
`ifdef ALU_EXEC_DBG_EN
            op_cnt_q    <= op_cnt_d;
`endif
        end
    end

    assign cmd_ready   = (state_q == ST_IDLE);
    assign rsp_valid   = (state_q == ST_RESP);
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_control = alu_ctrl_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_flags   = rsp_flags_q;
    assign rsp_err     = rsp_err_q;
`ifdef ALU_EXEC_DBG_EN
    assign dbg_op_cnt  = op_cnt_q;
`endif

endmodule : alu_exec_unit

// File: tb/tb_alu_exec_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_exec_unit
//   Two instances: unit 0 with EXEC_CYCLES = 1, unit 1 with EXEC_CYCLES = 3.
//   Each is attached to a behavioural ALU. A reference model (register
//   array + flag word) predicts every response. Directed scenarios are
//   followed by randomized command streams with random response back-pressure.
//   Debug ports are checked when ALU_EXEC_DBG_EN is defined.
// ---------------------------------------------------------------------------
module tb_alu_exec_unit;

    localparam logic [3:0] ADD = 4'd0, MUL = 4'd1, CMP = 4'd10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        cmd_valid [2];
    logic        cmd_ready [2];
    logic [3:0]  cmd_op [2];
    logic [2:0]  cmd_rd [2], cmd_ra [2], cmd_rb [2];
    logic        cmd_imm_sel [2];
    logic [31:0] cmd_imm [2];
    logic [31:0] alu_a [2], alu_b [2], alu_s [2];
    logic [3:0]  alu_control [2];
    logic [4:0]  alu_flg [2];
    logic        rsp_valid [2], rsp_ready [2], rsp_err [2];
    logic [31:0] rsp_data [2];
    logic [4:0]  rsp_flags [2], arch_flags [2];
`ifdef ALU_EXEC_DBG_EN
    logic [2:0]  dbg_addr [2];
    logic [31:0] dbg_data [2];
    logic [15:0] dbg_op_cnt [2];
`endif

    // reference model state
    logic [31:0] ref_regs [2][8];
    logic [4:0]  ref_flags [2];
    int          ref_opcnt [2];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    // Behavioural ALU: returns {zero, equalto, lessthan, overflow, carry, s}.
    function automatic logic [36:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] op);
        logic [32:0] wide;
        logic [63:0] prod;
        logic [31:0] s;
        logic        c, v, lt, eq;
        c = 1'b0; v = 1'b0; lt = 1'b0; eq = 1'b0; s = '0;
        case (op)
            4'd0: begin
                wide = {1'b0, a} + {1'b0, b};
                s = wide[31:0]; c = wide[32];
                v = (a[31] == b[31]) && (s[31] != a[31]);
            end
            4'd1: begin
                prod = 64'(a) * 64'(b);
                s = prod[31:0]; v = |prod[63:32];
            end
            4'd2: begin
                s = a - b; c = (a >= b);
                v = (a[31] != b[31]) && (s[31] != a[31]);
            end
            4'd3: s = a << b[4:0];
            4'd4: s = a >> b[4:0];
            4'd5: s = $signed(a) >>> b[4:0];
            4'd6: s = a & b;
            4'd7: s = a | b;
            4'd8: s = ~a;
            4'd9: s = a ^ b;
            4'd10: begin
                lt = $signed(a) < $signed(b);
                eq = (a == b);
                return {1'b0, eq, lt, 2'b00, 32'h0};
            end
            default: return {5'b10101, a ^ b ^ 32'hDEAD_BEEF};
        endcase
        return {(s == 32'h0), eq, lt, v, c, s};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        assign {alu_flg[g], alu_s[g]} = alu_fn(alu_a[g], alu_b[g], alu_control[g]);

        alu_exec_unit #(
            .NREGS       (8),
            .RW          (3),
            .EXEC_CYCLES ((g == 0) ? 1 : 3)
        ) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .cmd_valid    (cmd_valid[g]),
            .cmd_ready    (cmd_ready[g]),
            .cmd_op       (cmd_op[g]),
            .cmd_rd       (cmd_rd[g]),
            .cmd_ra       (cmd_ra[g]),
            .cmd_rb       (cmd_rb[g]),
            .cmd_imm_sel  (cmd_imm_sel[g]),
            .cmd_imm      (cmd_imm[g]),
            .alu_a        (alu_a[g]),
            .alu_b        (alu_b[g]),
            .alu_control  (alu_control[g]),
            .alu_s        (alu_s[g]),
            .alu_carry    (alu_flg[g][0]),
            .alu_overflow (alu_flg[g][1]),
            .alu_lessthan (alu_flg[g][2]),
            .alu_equalto  (alu_flg[g][3]),
            .alu_zero     (alu_flg[g][4]),
            .rsp_valid    (rsp_valid[g]),
            .rsp_ready    (rsp_ready[g]),
            .rsp_data     (rsp_data[g]),
            .rsp_flags    (rsp_flags[g]),
            .rsp_err      (rsp_err[g]),
            .flags_q      (arch_flags[g])
`ifdef ALU_EXEC_DBG_EN
            ,
            .dbg_addr     (dbg_addr[g]),
            .dbg_data     (dbg_data[g]),
            .dbg_op_cnt   (dbg_op_cnt[g])
`endif
        );
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic int exec_of(input int u);
        return (u == 0) ? 1 : 3;
    endfunction

    task automatic clear_model();
        for (int u = 0; u < 2; u++) begin
            for (int r = 0; r < 8; r++) ref_regs[u][r] = '0;
            ref_flags[u] = '0;
            ref_opcnt[u] = 0;
        end
    endtask

    // Issue one command on unit u, hold rsp_ready low for 'hold' cycles,
    // check everything against the model, then complete the handshake.
    task automatic issue(input int u, input logic [3:0] op, input logic [2:0] rd,
                         input logic [2:0] ra, input logic [2:0] rb, input logic imm_sel,
                         input logic [31:0] imm, input int hold,
                         output logic [31:0] got_data, output logic [4:0] got_flags);
        logic [31:0] a, b, exp_data;
        logic [36:0] r;
        logic [4:0]  exp_flg;
        logic        legal, stable;
        int          lat;

        a = ref_regs[u][ra];
        b = imm_sel ? imm : ref_regs[u][rb];
        r = alu_fn(a, b, op);
        legal    = (op <= CMP);
        exp_data = legal ? r[31:0] : 32'h0;
        exp_flg  = legal ? r[36:32] : 5'h0;
        if (legal && op != CMP && rd != 3'd0) ref_regs[u][rd] = r[31:0];
        if (legal) begin
            ref_flags[u] = r[36:32];
            ref_opcnt[u]++;
        end

        lat = 0;
        while (!cmd_ready[u] && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        check("cmd_ready_idle", cmd_ready[u], 1);

        cmd_op[u] = op; cmd_rd[u] = rd; cmd_ra[u] = ra; cmd_rb[u] = rb;
        cmd_imm_sel[u] = imm_sel; cmd_imm[u] = imm; cmd_valid[u] = 1'b1;
        @(posedge clk); #1;
        cmd_valid[u] = 1'b0;
        cmd_imm[u] = $urandom;  // operands must already be latched
        cmd_ra[u] = 3'($urandom); cmd_rb[u] = 3'($urandom);
        check("alu_a", alu_a[u], a);
        check("alu_b", alu_b[u], b);
        check("alu_control", alu_control[u], op);

        lat = 0; stable = 1'b1;
        while (!rsp_valid[u] && lat < 64) begin
            if (alu_a[u] !== a || alu_b[u] !== b || alu_control[u] !== op || cmd_ready[u])
                stable = 1'b0;
            @(posedge clk); #1; lat++;
        end
        check("rsp_latency", lat, exec_of(u) + 1);
        check("exec_inputs_stable", stable, 1);

        got_data = rsp_data[u]; got_flags = rsp_flags[u];
        stable = 1'b1;
        repeat (hold) begin
            @(posedge clk); #1;
            if (!rsp_valid[u] || cmd_ready[u] || rsp_data[u] !== got_data ||
                rsp_flags[u] !== got_flags) stable = 1'b0;
        end
        check("rsp_hold_stable", stable, 1);
        check("rsp_data", rsp_data[u], exp_data);
        check("rsp_flags", rsp_flags[u], exp_flg);
        check("rsp_err", rsp_err[u], !legal);
        check("flags_q", arch_flags[u], ref_flags[u]);

        rsp_ready[u] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[u] = 1'b0;
        check("rsp_valid_drop", rsp_valid[u], 0);
        check("cmd_ready_after", cmd_ready[u], 1);
    endtask

    // reg[r] observed as the result of r + 0 into r0
    task automatic read_reg(input int u, input logic [2:0] r, output logic [31:0] val);
        logic [4:0] f;
        issue(u, ADD, 3'd0, r, 3'd0, 1'b1, 32'h0, 0, val, f);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        logic [4:0]  f, saved;
        logic        seen;

        for (int u = 0; u < 2; u++) begin
            cmd_valid[u] = 0; cmd_op[u] = 0; cmd_rd[u] = 0; cmd_ra[u] = 0; cmd_rb[u] = 0;
            cmd_imm_sel[u] = 0; cmd_imm[u] = 0; rsp_ready[u] = 0;
`ifdef ALU_EXEC_DBG_EN
            dbg_addr[u] = 0;
`endif
        end
        clear_model();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // reset state
        for (int u = 0; u < 2; u++) begin
            check("rst_cmd_ready", cmd_ready[u], 1);
            check("rst_rsp_valid", rsp_valid[u], 0);
            check("rst_rsp_data", rsp_data[u], 0);
            check("rst_rsp_flags", rsp_flags[u], 0);
            check("rst_rsp_err", rsp_err[u], 0);
            check("rst_flags_q", arch_flags[u], 0);
            check("rst_alu_a", alu_a[u], 0);
            check("rst_alu_b", alu_b[u], 0);
            check("rst_alu_control", alu_control[u], 0);
        end

        // basic add chain on unit 0
        issue(0, ADD, 3'd1, 3'd0, 3'd0, 1'b1, 32'd5, 0, d, f);
        issue(0, ADD, 3'd2, 3'd0, 3'd0, 1'b1, 32'd7, 0, d, f);
        issue(0, ADD, 3'd3, 3'd1, 3'd2, 1'b0, 32'h0, 0, d, f);
        check("add_r1_r2", d, 32'd12);
        check("add_r1_r2_flags", f, 5'b00000);

        // carry out / zero
        issue(0, ADD, 3'd4, 3'd0, 3'd0, 1'b1, 32'hFFFF_FFFF, 0, d, f);
        issue(0, ADD, 3'd5, 3'd4, 3'd0, 1'b1, 32'd1, 1, d, f);
        check("wrap_data", d, 32'h0);
        check("wrap_flags_q", arch_flags[0], 5'b10001);
        read_reg(0, 3'd5, d);
        check("wrap_r5", d, 32'h0);

        // cmp: flags only, destination untouched
        issue(0, CMP, 3'd6, 3'd1, 3'd2, 1'b0, 32'h0, 0, d, f);
        check("cmp_lt_data", d, 32'h0);
        check("cmp_lt_flags", f, 5'b00100);
        issue(0, CMP, 3'd6, 3'd1, 3'd1, 1'b0, 32'h0, 0, d, f);
        check("cmp_eq_flags", f, 5'b01000);
        saved = arch_flags[0];
        read_reg(0, 3'd6, d);
        check("cmp_no_write", d, 32'h0);

        // illegal opcode
        issue(0, CMP, 3'd0, 3'd1, 3'd1, 1'b0, 32'h0, 0, d, f);
        saved = arch_flags[0];
        issue(0, 4'd12, 3'd7, 3'd1, 3'd2, 1'b0, 32'h0, 2, d, f);
        check("illegal_err", rsp_err[0], 1);
        check("illegal_data", d, 32'h0);
        check("illegal_flags_q_kept", arch_flags[0], saved);
        read_reg(0, 3'd7, d);
        check("illegal_no_write", d, 32'h0);

        // multicycle multiply on unit 1 with back-pressure
        issue(1, ADD, 3'd1, 3'd0, 3'd0, 1'b1, 32'h0001_0000, 0, d, f);
        issue(1, MUL, 3'd2, 3'd1, 3'd0, 1'b1, 32'h0001_0000, 5, d, f);
        check("mul_data", d, 32'h0);
        check("mul_overflow", f[1], 1);

        // reset during EXEC aborts the command
        cmd_op[0] = ADD; cmd_rd[0] = 3'd6; cmd_ra[0] = 3'd0; cmd_imm_sel[0] = 1'b1;
        cmd_imm[0] = 32'h55; cmd_valid[0] = 1'b1;
        @(posedge clk); #1;
        cmd_valid[0] = 1'b0;
        check("abort_in_exec", cmd_ready[0], 0);
        rst_n = 1'b0;
        clear_model();
        #1;
        check("abort_rst_ready", cmd_ready[0], 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("abort_post_ready", cmd_ready[0], 1);
        seen = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (rsp_valid[0]) seen = 1'b1;
        end
        check("abort_no_rsp", seen, 0);
        read_reg(0, 3'd6, d);
        check("abort_no_write", d, 32'h0);

        // randomized streams
        for (int u = 0; u < 2; u++) begin
            for (int n = 0; n < 120; n++) begin
                logic [3:0]  op;
                logic [31:0] imm;
                op = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(11, 15))
                                                 : 4'($urandom_range(0, 10));
                case ($urandom_range(0, 3))
                    0: imm = 32'($urandom_range(0, 40));
                    1: imm = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
                    2: imm = 32'h8000_0000 ^ 32'($urandom_range(0, 3));
                    default: imm = $urandom;
                endcase
                issue(u, op, 3'($urandom), 3'($urandom), 3'($urandom), 1'($urandom),
                      imm, $urandom_range(0, 3), d, f);
            end
        end

        // final register contents
        for (int u = 0; u < 2; u++) begin
            for (int r = 1; r < 8; r++) begin
                read_reg(u, 3'(r), d);
                check("final_reg", d, ref_regs[u][r]);
            end
        end

`ifdef ALU_EXEC_DBG_EN
        for (int u = 0; u < 2; u++) begin
            for (int r = 0; r < 8; r++) begin
                dbg_addr[u] = 3'(r);
                #1;
                check("dbg_data", dbg_data[u], ref_regs[u][r]);
            end
            check("dbg_op_cnt", dbg_op_cnt[u], 16'(ref_opcnt[u]));
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_alu_exec_unit
